// File: rtl/adc_capture_pkg.sv
// Purpose: shared types and helpers for the ADC burst capture block.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package adc_capture_pkg;

  // Capture sequencer states, in the order a reading walks through them.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    STORE,
    QUIET,
    DONE
  } adc_state_t;

  // The inter-frame quiet gap, measured in SCLK half periods.
  localparam int QUIET_HALVES = 2;

  // System clock cycles per SCLK half period.
  function automatic int half_period(input int clk_hz, input int sclk_hz);
    return clk_hz / (2 * sclk_hz);
  endfunction

endpackage

// File: rtl/adc_sample_ram.sv
// Purpose: sample buffer, simple dual port (1 write, 1 registered read), maps onto ECP5 EBR.
// Latency: read data 1 cycle after rd_addr_i; a same-cycle read of the written address returns old data.
// Backpressure: none, both ports accept every cycle.
//
// Ports:
//   clk_i, reset_ni         clock, async active-low reset (clears only the read register)
//   wr_en_i/addr/data       write port
//   rd_addr_i, rd_data_o    registered read port
module adc_sample_ram #(
  parameter int AddrBits = 13,
  parameter int DataBits = 12
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                wr_en_i,
  input  logic [AddrBits-1:0] wr_addr_i,
  input  logic [DataBits-1:0] wr_data_i,
  input  logic [AddrBits-1:0] rd_addr_i,
  output logic [DataBits-1:0] rd_data_o
);

  // Array contents are deliberately never reset so it maps onto block RAM.
  logic [DataBits-1:0] mem [2**AddrBits];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register samples the array before the write of the same edge lands.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/adc_burst_capture.sv
// Purpose: SPI master that runs a burst of ADC conversion frames and stores each sample in block RAM.
// Latency: 281 clk per reading at default clocks; rd_data_o 1 cycle after rd_addr_i.
// Backpressure: none; start_i is ignored while busy_o, and the read port never stalls.
//
// Ports:
//   clk_i, reset_ni            system clock, async active-low reset
//   start_i, burst_len_i       one-cycle burst request and reading count (0 ignored, clamped to depth)
//   busy_o, done_o, count_o    burst in progress, sticky completion flag, samples stored so far
//   rd_addr_i, rd_data_o       CPU read-back of stored samples (zero-extended to 16 bits)
//   adc_sclk_o, adc_miso_i,
//   adc_sync_no                ADC serial pins (SCLK idles high, SYNC active low)
module adc_burst_capture
  import adc_capture_pkg::*;
#(
  parameter int FPGAClkSpeed        = 40000000,
  parameter int ADCSPIClkSpeed      = 2500000,
  parameter int MaxADCBurstReadings = 13,
  parameter int FrameBits           = 16,
  parameter int SampleBits          = 12
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           start_i,
  input  logic [MaxADCBurstReadings:0]   burst_len_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [MaxADCBurstReadings:0]   count_o,
  input  logic [MaxADCBurstReadings-1:0] rd_addr_i,
  output logic [15:0]                    rd_data_o,
  output logic                           adc_sclk_o,
  input  logic                           adc_miso_i,
  output logic                           adc_sync_no
);

  localparam int HALF      = half_period(FPGAClkSpeed, ADCSPIClkSpeed);
  localparam int DEPTH     = 2 ** MaxADCBurstReadings;
  localparam int LW        = MaxADCBurstReadings + 1;
  localparam int QUIET_CYC = QUIET_HALVES * HALF;
  localparam int TW        = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam int BW        = (FrameBits > 1) ? $clog2(FrameBits) : 1;

  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF - 1);
  localparam logic [TW-1:0] QUIET_LAST = TW'(QUIET_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FrameBits - 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

  // SCLK must divide the system clock into a whole number of cycles per half period.
  if (ADCSPIClkSpeed < 1 || HALF < 1 || (FPGAClkSpeed % (2 * ADCSPIClkSpeed)) != 0 ||
      SampleBits < 2 || SampleBits > 16 || SampleBits > FrameBits) begin : g_bad_params
    $error("adc_burst_capture: clock ratio or sample width not supported");
  end

  adc_state_t          state_q, state_d;
  logic [TW-1:0]       tmr_q;
  logic [BW-1:0]       bit_q;
  // Only the last SampleBits bits of a frame survive, so that is all we shift.
  logic [SampleBits-1:0] shift_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       count_q;
  logic                done_q;
  logic                sclk_q;
  logic                sync_n_q;

  logic                accept;
  logic                rise;
  logic                fall;
  logic                wr_en;
  logic                tmr_clr;
  logic [SampleBits-1:0] ram_rd;

  // Next-state and strobe decode. The half-period timer is the only pacing source:
  // SETUP waits one half, each SHIFT half ends in an SCLK edge, QUIET waits QUIET_HALVES halves.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (burst_len_i != '0)) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tmr_q == HALF_LAST) begin
          fall    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tmr_q == HALF_LAST) begin
          if (!sclk_q) begin
            rise = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            // End of the high half after the last rising edge: SCLK stays high.
            state_d = STORE;
          end else begin
            fall = 1'b1;
          end
        end
      end
      STORE: begin
        wr_en   = 1'b1;
        state_d = QUIET;
      end
      QUIET: begin
        if (tmr_q == QUIET_LAST) begin
          state_d = (count_q == len_q) ? DONE : SETUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The timer restarts on every state change and on every SCLK edge.
  assign tmr_clr = (state_q == IDLE) || (state_d != state_q) || rise || fall;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tmr_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      len_q    <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
    end else begin
      tmr_q <= tmr_clr ? '0 : tmr_q + 1'b1;

      // SCLK is a register so the pin never glitches on state decode.
      if (fall) begin
        sclk_q <= 1'b0;
      end else if (rise) begin
        sclk_q <= 1'b1;
      end

      // MISO is captured on the same edge that drives SCLK high.
      if (rise) begin
        shift_q <= {shift_q[SampleBits-2:0], adc_miso_i};
      end

      // Bits completed in this frame; a falling edge inside SHIFT closes one period.
      if (state_d == SETUP) begin
        bit_q <= '0;
      end else if (fall && (state_q == SHIFT)) begin
        bit_q <= bit_q + 1'b1;
      end

      sync_n_q <= !((state_d == SETUP) || (state_d == SHIFT));

      if (accept) begin
        len_q   <= (burst_len_i > DEPTH_L) ? DEPTH_L : burst_len_i;
        count_q <= '0;
        done_q  <= 1'b0;
      end else if (wr_en) begin
        count_q <= count_q + 1'b1;
      end

      if (state_d == DONE) begin
        done_q <= 1'b1;
      end
    end
  end

  adc_sample_ram #(
    .AddrBits (MaxADCBurstReadings),
    .DataBits (SampleBits)
  ) u_ram (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .wr_en_i   (wr_en),
    .wr_addr_i (count_q[MaxADCBurstReadings-1:0]),
    .wr_data_i (shift_q),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (ram_rd)
  );

  assign rd_data_o   = 16'(ram_rd);
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = done_q;
  assign count_o     = count_q;
  assign adc_sclk_o  = sclk_q;
  assign adc_sync_no = sync_n_q;

endmodule

// File: tb/tb_adc_burst_capture.sv
// Purpose: self-checking bench for adc_burst_capture with an ADC serial model and scoreboards.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_adc_burst_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni    = 1'b0;
  logic        start_i     = 1'b0;
  logic [13:0] burst_len_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [13:0] count_o;
  logic [12:0] rd_addr_i   = '0;
  logic [15:0] rd_data_o;
  logic        adc_sclk_o;
  logic        adc_miso_i  = 1'b0;
  logic        adc_sync_no;

  // Small instance (HALF=1, depth 16) used for the length clamp.
  logic        s_start     = 1'b0;
  logic [4:0]  s_len       = '0;
  logic        s_busy;
  logic        s_done;
  logic [4:0]  s_count;
  logic [3:0]  s_rd_addr   = '0;
  logic [15:0] s_rd_data;
  logic        s_sclk;
  logic        s_miso      = 1'b1;
  logic        s_sync;

  adc_burst_capture dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .burst_len_i (burst_len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .count_o     (count_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .adc_sclk_o  (adc_sclk_o),
    .adc_miso_i  (adc_miso_i),
    .adc_sync_no (adc_sync_no)
  );

  adc_burst_capture #(
    .FPGAClkSpeed        (2),
    .ADCSPIClkSpeed      (1),
    .MaxADCBurstReadings (4)
  ) u_small (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .start_i     (s_start),
    .burst_len_i (s_len),
    .busy_o      (s_busy),
    .done_o      (s_done),
    .count_o     (s_count),
    .rd_addr_i   (s_rd_addr),
    .rd_data_o   (s_rd_data),
    .adc_sclk_o  (s_sclk),
    .adc_miso_i  (s_miso),
    .adc_sync_no (s_sync)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int count;
    int busy;
  } burst_exp_t;

  burst_exp_t  exp_burst[$];
  int          exp_rd[$];
  logic [15:0] frames[$];

  // ADC model: loads the next frame when SYNC falls, presents the next MSB after
  // each SCLK fall, and corrupts the line after each SCLK rise so a late sample is caught.
  logic [15:0] cur = '0;
  logic m_sync_p = 1'b1, m_sclk_p = 1'b1;
  always @(negedge clk) begin
    if (m_sync_p && !adc_sync_no) begin
      cur = (frames.size() != 0) ? frames.pop_front() : 16'h0000;
    end
    if (m_sclk_p && !adc_sclk_o) begin
      adc_miso_i = cur[15];
      cur = {cur[14:0], 1'b0};
    end else if (!m_sclk_p && adc_sclk_o) begin
      adc_miso_i = ~adc_miso_i;
    end
    m_sync_p = adc_sync_no;
    m_sclk_p = adc_sclk_o;
  end

  int sclk_falls = 0;
  always @(negedge adc_sclk_o) sclk_falls++;

  // Burst monitor: a completed burst is the first non-busy cycle after a busy run.
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!reset_ni) begin
      busy_cnt = 0;
    end else if (busy_o) begin
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      if (exp_burst.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL burst_unexpected: burst ended with count %0d, none expected", count_o);
      end else begin
        burst_exp_t e;
        e = exp_burst.pop_front();
        check("burst_busy_cycles", busy_cnt, e.busy);
        check("burst_count", int'(count_o), e.count);
        check("burst_done", int'(done_o), 1);
      end
      busy_cnt = 0;
    end
  end

  // Read monitor: data is due one cycle after the address was presented.
  logic rd_vld = 1'b0, rd_vld_d = 1'b0;
  always @(posedge clk) rd_vld_d <= rd_vld;
  always @(negedge clk) begin
    if (rd_vld_d) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h with nothing expected", rd_data_o);
      end else begin
        check("rd_data", int'(rd_data_o), exp_rd.pop_front());
      end
    end
  end

  // Frame monitor: SYNC low length, SCLK pulse count, first fall, quiet gap, idle SCLK.
  int low_cnt = 0, pulses = 0, fall_at = 0, gap = 0, idle_low = 0;
  bit in_frame = 1'b0, gap_ok = 1'b0;
  logic f_sync_p = 1'b1, f_sclk_p = 1'b1;
  always @(negedge clk) begin
    if (!reset_ni) begin
      in_frame = 1'b0;
      gap_ok   = 1'b0;
    end else begin
      if (f_sync_p && !adc_sync_no) begin
        if (gap_ok) begin
          checks++;
          if (gap < 16) begin
            errors++;
            $display("FAIL quiet_gap: got %0d cycles, required at least 16", gap);
          end
        end
        check("sclk_idle_high", idle_low, 0);
        in_frame = 1'b1;
        low_cnt  = 0;
        pulses   = 0;
        fall_at  = 0;
      end
      if (!adc_sync_no && in_frame) begin
        low_cnt++;
        if (!f_sclk_p && adc_sclk_o) pulses++;
        if (f_sclk_p && !adc_sclk_o && fall_at == 0) fall_at = low_cnt;
      end
      if (!f_sync_p && adc_sync_no && in_frame) begin
        check("frame_sync_low", low_cnt, 264);
        check("frame_sclk_pulses", pulses, 16);
        check("frame_first_fall", fall_at, 9);
        in_frame = 1'b0;
        gap      = 0;
        gap_ok   = 1'b1;
      end
      if (adc_sync_no) gap++;
      if (adc_sync_no && !adc_sclk_o) idle_low++;
      if (!busy_o) gap_ok = 1'b0;
    end
    f_sync_p = adc_sync_no;
    f_sclk_p = adc_sclk_o;
  end

  task automatic start_burst(input int len, input bit expect_end, input int exp_count,
                             input int exp_busy);
    @(negedge clk);
    start_i     = 1'b1;
    burst_len_i = 14'(len);
    if (expect_end) exp_burst.push_back('{exp_count, exp_busy});
    @(negedge clk);
    start_i     = 1'b0;
    burst_len_i = '0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy_o still %0d after %0d cycles", busy_o, max_cycles);
    end
    @(negedge clk);
  endtask

  task automatic rd(input int addr, input int exp);
    @(negedge clk);
    rd_addr_i = 13'(addr);
    rd_vld    = 1'b1;
    exp_rd.push_back(exp);
    @(negedge clk);
    rd_vld    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    int busy_seen;
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_sclk", int'(adc_sclk_o), 1);
    check("rst_sync", int'(adc_sync_no), 1);
    check("rst_rd_data", int'(rd_data_o), 0);
    reset_ni = 1'b1;

    // Single reading.
    frames.push_back(16'h0ABC);
    start_burst(1, 1'b1, 1, 281);
    wait_idle(400);
    rd(0, 'h0ABC);

    // Four-reading burst; top frame bits are masked.
    frames.push_back(16'h0001);
    frames.push_back(16'h0FFF);
    frames.push_back(16'h0800);
    frames.push_back(16'hF123);
    start_burst(4, 1'b1, 4, 1124);
    check("start_busy", int'(busy_o), 1);
    check("start_sync", int'(adc_sync_no), 0);
    check("start_done_clr", int'(done_o), 0);
    check("start_count_clr", int'(count_o), 0);
    wait_idle(1300);
    rd(0, 'h0001);
    rd(1, 'h0FFF);
    rd(2, 'h0800);
    rd(3, 'h0123);

    // Zero length is ignored.
    f0 = sclk_falls;
    busy_seen = 0;
    start_burst(0, 1'b0, 0, 0);
    repeat (50) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
    end
    check("zero_len_busy", busy_seen, 0);
    check("zero_len_sclk", sclk_falls - f0, 0);
    check("zero_len_count", int'(count_o), 4);
    check("zero_len_done", int'(done_o), 1);

    // Start while busy (during reading 2) is ignored.
    frames.push_back(16'h0123);
    frames.push_back(16'h0456);
    frames.push_back(16'h0789);
    frames.push_back(16'h0ABC);
    start_burst(4, 1'b1, 4, 1124);
    repeat (350) @(negedge clk);
    start_i     = 1'b1;
    burst_len_i = 14'd2;
    @(negedge clk);
    start_i     = 1'b0;
    burst_len_i = '0;
    wait_idle(1300);
    rd(1, 'h0456);
    rd(3, 'h0ABC);

    // Reset during SHIFT of reading 3.
    frames.push_back(16'h0111);
    frames.push_back(16'h0222);
    frames.push_back(16'h0333);
    frames.push_back(16'h0444);
    start_burst(4, 1'b0, 0, 0);
    repeat (600) @(negedge clk);
    #2 reset_ni = 1'b0;
    @(negedge clk);
    check("mid_rst_sync", int'(adc_sync_no), 1);
    check("mid_rst_sclk", int'(adc_sclk_o), 1);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_count", int'(count_o), 0);
    check("mid_rst_rd_data", int'(rd_data_o), 0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    frames.delete();

    // A fresh burst after reset behaves normally.
    frames.push_back(16'h0FED);
    frames.push_back(16'h0321);
    start_burst(2, 1'b1, 2, 562);
    wait_idle(700);
    rd(0, 'h0FED);
    rd(1, 'h0321);

    // Clamp: 31 readings requested of a 16-deep buffer, MISO held high.
    @(negedge clk);
    s_start = 1'b1;
    s_len   = 5'd31;
    @(negedge clk);
    s_start = 1'b0;
    s_len   = '0;
    n = 0;
    while (s_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("clamp_busy_cycles", n, 576);
    check("clamp_count", int'(s_count), 16);
    check("clamp_done", int'(s_done), 1);
    s_rd_addr = 4'd15;
    @(negedge clk);
    check("clamp_rd_last", int'(s_rd_data), 'h0FFF);

    repeat (5) @(negedge clk);
    check("burst_queue_empty", exp_burst.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
